// File: rtl/data_bus_mmio.sv
// data_bus_mmio: word RAM plus LED, TX FIFO, timer, compare and IRQ registers behind the core's load/store port
module data_bus_mmio #(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   timer, cmp;
    logic [29:0]   word, mmio_off;
    logic          sel_ram, sel_led, sel_tx, sel_timer, sel_cmp, sel_irq;
    logic          full, pop, push_req, push, match;
    logic          unused_addr;
    assign unused_addr = ^ALUResult[1:0];
    assign word      = ALUResult[31:2];
    assign mmio_off  = word - MMIO_BASE[31:2];
    assign sel_ram   = (word >> AW) == 30'd0;
    assign sel_led   = !sel_ram && mmio_off == 30'd0;
    assign sel_tx    = !sel_ram && mmio_off == 30'd1;
    assign sel_timer = !sel_ram && mmio_off == 30'd2;
    assign sel_cmp   = !sel_ram && mmio_off == 30'd3;
    assign sel_irq   = !sel_ram && mmio_off == 30'd4;
    assign full      = count == CW'(FIFO_DEPTH);
    assign tx_valid  = count != '0;
    assign tx_data   = fifo[rd_ptr];
    assign pop       = tx_valid & tx_ready;
    assign push_req  = MemWrite & sel_tx;
    // a full FIFO still accepts a byte when the head leaves on the same edge
    assign push      = push_req & (!full | pop);
    assign match     = cmp != '0 && timer == cmp;
    always_comb begin
        ReadData = sel_ram   ? ram[word[AW-1:0]] :
                   sel_led   ? {24'b0, led} :
                   sel_tx    ? {22'b0, overflow, 8'(count), full} :
                   sel_timer ? timer :
                   sel_cmp   ? cmp :
                   sel_irq   ? {31'b0, irq} : 32'b0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            led      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            timer    <= '0;
            cmp      <= '0;
            irq      <= 1'b0;
        end else begin
            if (MemWrite & sel_led) led <= WriteData[7:0];
            if (MemWrite & sel_cmp) cmp <= WriteData;
            timer <= (MemWrite & sel_timer) ? WriteData : timer + 32'd1;
            // a match on the pre-edge timer beats a same-cycle clear
            irq <= match | (irq & !(MemWrite & sel_irq));
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (push_req & !push) overflow <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset && MemWrite && sel_ram) ram[word[AW-1:0]] <= WriteData;
        if (push) fifo[wr_ptr] <= WriteData[7:0];
    end
endmodule

// File: tb/tb_data_bus_mmio.sv
// tb_data_bus_mmio: directed stimulus with queued expectations checked by a separate monitor
module tb_data_bus_mmio;
    localparam logic [31:0] B = 32'h0000_1000;
    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;
    logic        clk = 1'b0;
    logic        reset, MemWrite, tx_ready, tx_valid, irq;
    logic [31:0] ALUResult, WriteData, ReadData;
    logic [7:0]  led, tx_data;
    chk_t        chkq[$];
    logic [7:0]  txq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    data_bus_mmio dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .ReadData(ReadData), .led(led), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
    );
    always #5 clk = ~clk;
    function automatic void check(string n, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endfunction
    function automatic void want(int kind, logic [31:0] e, string n);
        chk_t c;
        c.name = n;
        c.kind = kind;
        c.exp  = e;
        chkq.push_back(c);
    endfunction
    always @(negedge clk) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (txq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_unexpected: got byte %h expected none", tx_data);
            end else check("tx_data", {24'b0, tx_data}, {24'b0, txq.pop_front()});
        end
        while (chkq.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c = chkq.pop_front();
            act = c.kind == 0 ? ReadData :
                  c.kind == 1 ? {24'b0, led} :
                  c.kind == 2 ? {31'b0, irq} : {31'b0, tx_valid};
            check(c.name, act, c.exp);
        end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(logic [31:0] a, logic [31:0] d);
        MemWrite = 1'b1;
        ALUResult = a;
        WriteData = d;
    endtask
    task automatic wr(logic [31:0] a, logic [31:0] d);
        drive(a, d);
        cyc();
        MemWrite = 1'b0;
    endtask
    task automatic rd(logic [31:0] a, logic [31:0] e, string n);
        ALUResult = a;
        want(0, e, n);
        cyc();
    endtask
    task automatic drain(string n);
        int k = 0;
        tx_ready = 1'b1;
        while (tx_valid === 1'b1 && k < 20) begin
            cyc();
            k++;
        end
        tx_ready = 1'b0;
        check(n, k, 8);
        want(3, 0, {n, "_empty"});
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
    initial begin
        reset = 1'b1;
        MemWrite = 1'b0;
        tx_ready = 1'b0;
        ALUResult = '0;
        WriteData = '0;
        repeat (2) cyc();
        want(1, 0, "rst_led");
        want(2, 0, "rst_irq");
        want(3, 0, "rst_tx_valid");
        rd(B + 32'h08, 0, "rst_timer");
        rd(B + 32'h04, 0, "rst_tx_status");
        rd(B + 32'h0C, 0, "rst_cmp");
        reset = 1'b0;
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, 32'hDEAD_BEEF, "ram_rd");
        rd(32'h13, 32'hDEAD_BEEF, "ram_rd_unaligned");
        rd(B + 32'h40, 0, "unmapped_rd");
        wr(32'h00, 32'h1111_1111);
        wr(32'h100, 32'h2222_2222);
        wr(32'hFC, 32'h1234_5678);
        rd(32'hFC, 32'h1234_5678, "ram_top");
        rd(32'h100, 0, "ram_past_end");
        rd(32'h00, 32'h1111_1111, "ram_no_alias");
        wr(B, 32'h0000_01A5);
        want(1, 32'hA5, "led");
        rd(B, 32'hA5, "led_rd");
        wr(B + 32'h08, 100);
        rd(B + 32'h08, 100, "tmr_load");
        rd(B + 32'h08, 101, "tmr_inc");
        wr(B + 32'h08, 32'hFFFF_FFFF);
        rd(B + 32'h08, 32'hFFFF_FFFF, "tmr_max");
        rd(B + 32'h08, 0, "tmr_wrap");
        reset = 1'b1;
        drive(B, 32'hFF);
        cyc();
        MemWrite = 1'b0;
        want(1, 0, "led_reset_wins");
        rd(B + 32'h08, 0, "tmr_reset");
        reset = 1'b0;
        wr(B + 32'h08, 32'h1000);
        wr(B + 32'h0C, 5);
        rd(B + 32'h0C, 5, "cmp_rd");
        wr(B + 32'h08, 0);
        repeat (5) cyc();
        ALUResult = B + 32'h08;
        want(0, 5, "tmr_at_5");
        want(2, 0, "irq_before_match");
        cyc();
        want(2, 1, "irq_set");
        rd(B + 32'h10, 1, "irq_rd");
        wr(B + 32'h10, 0);
        want(2, 0, "irq_clr");
        rd(B + 32'h10, 0, "irq_clr_rd");
        wr(B + 32'h08, 0);
        repeat (5) cyc();
        wr(B + 32'h10, 0);
        want(2, 1, "irq_race_set_wins");
        wr(B + 32'h10, 0);
        want(2, 0, "irq_clr2");
        wr(B + 32'h08, 0);
        repeat (5) cyc();
        wr(B + 32'h08, 32'h500);
        want(2, 1, "irq_load_keeps_match");
        rd(B + 32'h08, 32'h500, "tmr_loaded");
        wr(B + 32'h10, 0);
        wr(B + 32'h0C, 0);
        wr(B + 32'h08, 0);
        repeat (3) cyc();
        want(2, 0, "irq_cmp0");
        drive(B + 32'h04, 1);
        want(3, 0, "tx_no_bypass");
        txq.push_back(8'd1);
        cyc();
        MemWrite = 1'b0;
        want(3, 1, "tx_valid_rise");
        rd(B + 32'h04, 32'h2, "tx_status_1");
        for (int i = 2; i <= 8; i++) begin
            wr(B + 32'h04, i);
            txq.push_back(8'(i));
        end
        rd(B + 32'h04, 32'h11, "tx_status_full");
        wr(B + 32'h04, 9);
        rd(B + 32'h04, 32'h211, "tx_status_ovf");
        drain("drain_fill");
        rd(B + 32'h04, 32'h200, "tx_ovf_sticky");
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(B + 32'h04, 32'h10 + i);
            txq.push_back(8'(8'h10 + i));
        end
        tx_ready = 1'b1;
        drive(B + 32'h04, 32'h77);
        txq.push_back(8'h77);
        cyc();
        MemWrite = 1'b0;
        tx_ready = 1'b0;
        rd(B + 32'h04, 32'h11, "tx_sim_status");
        drain("drain_sim");
        repeat (2) cyc();
        check("chk_queue_left", chkq.size(), 0);
        check("tx_queue_left", txq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_bus_mmio.md
Name: data_bus_mmio

Overview:
- Data-side memory subsystem directly downstream of the single-cycle ARM core.
- Consumes the core's MemWrite, ALUResult (address) and WriteData, and returns ReadData in the same cycle.
- Decodes each address to a word-addressed data RAM or one of five memory-mapped peripheral registers: LED register, TX byte FIFO with valid/ready drain, free-running timer, timer compare, and sticky IRQ flag.

Parameters:
- RAM_WORDS, 64, number of 32-bit data RAM words; power of two.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
- MMIO_BASE, 32'h0000_1000, byte base address of the peripheral register window.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- MemWrite  in  1  store strobe from core
- ALUResult  in  32  byte address from core; bits [1:0] ignored
- WriteData  in  32  store data from core
- ReadData  out  32  load data to core, combinational from address
- led  out  8  LED register
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  downstream consumer accepts head
- irq  out  1  sticky timer-match flag

Behaviour:
- Address map, word-aligned:
  - RAM: 0 to RAM_WORDS*4-1.
  - MMIO_BASE+0x00: LED (RW, bits [7:0]).
  - +0x04: TX (write pushes WriteData[7:0]; read returns status {22'b0, overflow, count[7:0], full}). count is zero-extended to 8 bits.
  - +0x08: TIMER (RW).
  - +0x0C: CMP (RW).
  - +0x10: IRQ (read {31'b0, irq}; any write clears).
  - Any other address: reads return 0, writes are ignored.
- Reads are purely combinational; no read side effects. Required because the core completes a load in one cycle.
- Writes take effect at the rising clk edge when MemWrite=1.
- RAM: asynchronous read, synchronous write, contents not reset.
- Reset (synchronous): led=0, FIFO empty (count=0, tx_valid=0), overflow=0, TIMER=0, CMP=0, irq=0. Reset has priority over every write, push, pop and increment.
- FIFO:
  - tx_valid = (count!=0); tx_data = head entry.
  - Pop occurs when tx_valid & tx_ready at the edge.
  - Push occurs on a write to TX when count<FIFO_DEPTH, or when full and a pop happens in the same cycle.
  - Push while full with no pop: byte dropped, overflow set (sticky until reset).
  - Push and pop in the same cycle: count unchanged; pointers both advance and wrap modulo FIFO_DEPTH.
  - Push into empty: tx_valid rises the next cycle (no bypass).
  - full = (count==FIFO_DEPTH).
- TIMER:
  - Increments by 1 every cycle; wraps 32'hFFFF_FFFF to 0.
  - A write to TIMER loads WriteData instead of incrementing that cycle.
- IRQ:
  - At each edge, irq is set if CMP!=0 and the pre-edge TIMER==CMP.
  - A write to IRQ clears it.
  - Set and clear in the same cycle: set wins.
  - A TIMER load does not suppress a match of the pre-edge value.
- Latency: store visible to a load on the next cycle; MMIO outputs (led, irq, tx_valid) update one cycle after the causing edge.

Test Plan:
- RAM: write 32'hDEADBEEF to addr 0x10, next cycle read 0x10 and 0x13 -> both 32'hDEADBEEF. Read MMIO_BASE+0x40 -> 0.
- LED: write 32'h0000_01A5 to MMIO_BASE -> led=8'hA5 next cycle. Assert reset for one cycle -> led=0, TIMER=0.
- FIFO fill/overflow: tx_ready=0, push bytes 1..9 -> after the 8th push full=1, count=8. The 9th push sets overflow=1. Then tx_ready=1 -> tx_data drains 1..8 in order, tx_valid drops after 8 pops.
- FIFO simultaneous: with the FIFO full and tx_ready=1, push 8'h77 -> count stays 8, overflow stays 0, 8'h77 emerges last.
- Timer/IRQ: write CMP=5, write TIMER=0 -> irq=1 on the edge where TIMER was 5. Write IRQ to clear -> irq=0. Write TIMER=32'hFFFF_FFFF -> next value 0. CMP=0 never sets irq.
- Set/clear race: IRQ write on the exact match cycle -> irq remains 1.
